// File: rtl/scm_gen.sv
// scm_gen: parametrised 1R1W standard-cell memory macro.
//
// Storage is one gated row per word. Writes go through a one-entry pending
// register and commit to the array one edge later. Reads are registered with
// a one-cycle latency. A read forwards, per byte lane, from a pending write
// that commits on the same edge.
//
// Ports:
//   CLK     in   rising-edge clock
//   RSTN    in   asynchronous active-low reset
//   SE      in   scan enable, forces every clock gate open
//   WE      in   write request
//   WADDR   in   [AW-1:0]    write address
//   WMASK   in   [NB-1:0]    byte-lane write enable, bit i -> DIN[8i+7:8i]
//   DIN     in   [WIDTH-1:0] write data
//   RE      in   read request
//   RADDR   in   [AW-1:0]    read address
//   DOUT    out  [WIDTH-1:0] registered read data
//   RVALID  out  strobe, DOUT was updated at the last edge
//   AERR    out  strobe, a request at the last edge had address >= DEPTH
module scm_gen #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             SE,
  input  logic             WE,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH/8-1:0] WMASK,
  input  logic [WIDTH-1:0] DIN,
  input  logic             RE,
  input  logic [AW-1:0]    RADDR,
  output logic [WIDTH-1:0] DOUT,
  output logic             RVALID,
  output logic             AERR
);

  localparam int unsigned NB = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             pend_vld;
  logic [AW-1:0]    pend_addr;
  logic [WIDTH-1:0] pend_data;
  logic [NB-1:0]    pend_mask;

  logic             w_ok;
  logic             r_ok;
  logic             cg_wcap;
  logic             cg_rd;
  logic [DEPTH-1:0] row_sel;
  logic [DEPTH-1:0] row_cg;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] rd_next;

  // Addresses are zero-extended to 32 bits so the compare is unsigned.
  assign w_ok = WE && (32'(WADDR) < DEPTH);
  assign r_ok = RE && (32'(RADDR) < DEPTH);

  // Clock-gate enables. SE opens the gates; the register update itself stays
  // qualified by the functional condition, so scan never changes data.
  assign cg_wcap = WE | SE;
  assign cg_rd   = RE | SE;

  always_comb begin
    row_sel = '0;
    for (int r = 0; r < DEPTH; r++) begin
      row_sel[r] = pend_vld && (pend_addr == AW'(r));
    end
  end

  assign row_cg = row_sel | {DEPTH{SE}};

  // Control state. Clearing pend_vld on reset discards an uncommitted write.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pend_vld <= 1'b0;
      AERR     <= 1'b0;
    end else begin
      pend_vld <= w_ok;
      AERR     <= (WE && !w_ok) || (RE && !r_ok);
    end
  end

  // Pending write payload. It is never read while pend_vld is low, so it
  // needs no reset.
  always_ff @(posedge CLK) begin
    if (cg_wcap && w_ok) begin
      pend_addr <= WADDR;
      pend_data <= DIN;
      pend_mask <= WMASK;
    end
  end

  // Array rows. These are deliberately not reset.
  always_ff @(posedge CLK) begin
    for (int r = 0; r < DEPTH; r++) begin
      if (row_cg[r] && row_sel[r]) begin
        for (int b = 0; b < NB; b++) begin
          if (pend_mask[b]) mem[r][8*b +: 8] <= pend_data[8*b +: 8];
        end
      end
    end
  end

  // Full AW-bit decode. Codes at or above DEPTH select nothing and read 0.
  always_comb begin
    rd_word = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (RADDR == AW'(r)) rd_word = mem[r];
    end
  end

  // Per-lane forwarding from the write that commits on this same edge.
  always_comb begin
    rd_next = '0;
    if (r_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (pend_vld && (pend_addr == RADDR) && pend_mask[b])
          rd_next[8*b +: 8] = pend_data[8*b +: 8];
        else
          rd_next[8*b +: 8] = rd_word[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      DOUT   <= '0;
      RVALID <= 1'b0;
    end else begin
      RVALID <= RE;
      if (cg_rd && RE) DOUT <= rd_next;
    end
  end

endmodule

// File: tb/tb_scm_gen.sv
// tb_scm_gen: directed and random checks of scm_gen with WIDTH=32,
// DEPTH=200, AW=8.
//
// The reference model treats the memory as a plain array. A write becomes
// visible to every read sampled at a later edge. A reset that arrives before
// the next edge cancels the most recent write.
module tb_scm_gen;

  localparam int W  = 32;
  localparam int D  = 200;
  localparam int A  = 8;
  localparam int NB = W / 8;

  logic          CLK    = 1'b0;
  logic          RSTN   = 1'b0;
  logic          SE     = 1'b0;
  logic          WE     = 1'b0;
  logic [A-1:0]  WADDR  = '0;
  logic [NB-1:0] WMASK  = '0;
  logic [W-1:0]  DIN    = '0;
  logic          RE     = 1'b0;
  logic [A-1:0]  RADDR  = '0;
  logic [W-1:0]  DOUT;
  logic          RVALID;
  logic          AERR;

  scm_gen #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
    .CLK(CLK), .RSTN(RSTN), .SE(SE), .WE(WE), .WADDR(WADDR), .WMASK(WMASK),
    .DIN(DIN), .RE(RE), .RADDR(RADDR), .DOUT(DOUT), .RVALID(RVALID), .AERR(AERR)
  );

  always #5 CLK = ~CLK;

  logic [W-1:0] m_mem [D];
  logic [W-1:0] e_dout = '0;
  logic         e_rv   = 1'b0;
  logic         e_aerr = 1'b0;
  bit           undo_v = 1'b0;
  int           undo_a = 0;
  logic [W-1:0] undo_d = '0;
  int           n_cmp  = 0;
  int           n_err  = 0;

  function automatic logic [W-1:0] merge(input logic [W-1:0] old_w,
                                         input logic [W-1:0] new_w,
                                         input logic [NB-1:0] m);
    logic [W-1:0] r;
    r = old_w;
    for (int b = 0; b < NB; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    check("rvalid", W'(RVALID), W'(e_rv));
    check("aerr",   W'(AERR),   W'(e_aerr));
    check("dout",   DOUT,       e_dout);
  endtask

  // One clock cycle: drive the request, take the edge, update the model,
  // and check the registered outputs.
  task automatic step(input bit we, input int wa, input logic [NB-1:0] wm,
                      input logic [W-1:0] d, input bit re, input int ra);
    WE = we; WADDR = A'(wa); WMASK = wm; DIN = d;
    RE = re; RADDR = A'(ra);
    @(posedge CLK);
    e_rv   = re;
    e_aerr = (we && wa >= D) || (re && ra >= D);
    if (re) e_dout = (ra < D) ? m_mem[ra] : '0;
    undo_v = 1'b0;
    if (we && wa < D) begin
      undo_v = 1'b1;
      undo_a = wa;
      undo_d = m_mem[wa];
      m_mem[wa] = merge(m_mem[wa], d, wm);
    end
    #1;
    check_outs();
  endtask

  task automatic idle();
    step(1'b0, 0, '0, '0, 1'b0, 0);
  endtask

  // Assert reset mid-cycle, after the last edge and before the next one.
  task automatic do_reset();
    #2;
    RSTN = 1'b0;
    if (undo_v) m_mem[undo_a] = undo_d;
    undo_v = 1'b0;
    e_dout = '0; e_rv = 1'b0; e_aerr = 1'b0;
    WE = 1'b0; RE = 1'b0;
    #1;
    check_outs();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check_outs();
    #3;
    RSTN = 1'b1;
  endtask

  int wa_r, ra_r;

  initial begin
    // Power-up reset.
    #3;
    check_outs();
    @(posedge CLK);
    #4;
    RSTN = 1'b1;

    // Give every word a known value, back to back.
    for (int a = 0; a < D; a++) step(1'b1, a, '1, W'($urandom), 1'b0, 0);

    // Full write, read two cycles later, single-cycle RVALID.
    step(1'b1, 3, 4'hF, 32'h0000_A5C3, 1'b0, 0);
    idle();
    step(1'b0, 0, '0, '0, 1'b1, 3);
    check("t1_dout", DOUT, 32'h0000_A5C3);
    idle();
    check("t1_rv_drop", W'(RVALID), '0);

    // Lane-masked write, then a forwarded read and an array read.
    step(1'b1, 7, 4'hF, 32'h0000_1234, 1'b0, 0);
    idle();
    step(1'b1, 7, 4'b0001, 32'hFFFF_FFFF, 1'b0, 0);
    step(1'b0, 0, '0, '0, 1'b1, 7);
    check("t2_fwd", DOUT, 32'h0000_12FF);
    idle();
    step(1'b0, 0, '0, '0, 1'b1, 7);
    check("t2_array", DOUT, 32'h0000_12FF);

    // A read on the same edge as a write to that address returns old data.
    step(1'b1, 9, 4'hF, 32'h0000_0001, 1'b0, 0);
    idle();
    step(1'b1, 9, 4'hF, 32'h0000_BEEF, 1'b1, 9);
    check("t3_old", DOUT, 32'h0000_0001);
    step(1'b0, 0, '0, '0, 1'b1, 9);
    check("t3_new", DOUT, 32'h0000_BEEF);

    // Out-of-range write and read, then a scan for collateral damage.
    step(1'b1, 210, 4'hF, 32'h0000_5555, 1'b1, 210);
    check("t4_aerr", W'(AERR), W'(1));
    check("t4_dout", DOUT, '0);
    check("t4_rv", W'(RVALID), W'(1));
    idle();
    check("t4_aerr_drop", W'(AERR), '0);
    step(1'b1, 255, 4'hF, 32'h1, 1'b0, 0);
    step(1'b0, 0, '0, '0, 1'b1, 199);
    step(1'b0, 0, '0, '0, 1'b1, 200);
    for (int a = 0; a < D; a++) step(1'b0, 0, '0, '0, 1'b1, a);

    // A write cut off by reset before its commit edge.
    step(1'b1, 4, 4'hF, 32'hDEAD_BEEF, 1'b0, 0);
    do_reset();
    step(1'b0, 0, '0, '0, 1'b1, 4);
    // A read sampled just before reset produces no strobe.
    step(1'b0, 0, '0, '0, 1'b1, 5);
    do_reset();
    idle();

    // Scan enable alone must not disturb anything.
    SE = 1'b1;
    for (int i = 0; i < 10; i++) idle();
    for (int a = 0; a < 16; a++) step(1'b1, a, '1, W'($urandom), 1'b0, 0);
    for (int a = 0; a < 16; a++) step(1'b0, 0, '0, '0, 1'b1, a);
    SE = 1'b0;
    for (int a = 0; a < 16; a++) step(1'b1, a, '1, W'($urandom), 1'b0, 0);
    for (int a = 0; a < 16; a++) step(1'b0, 0, '0, '0, 1'b1, a);

    // Random traffic on a few hot addresses plus occasional out-of-range ones.
    for (int i = 0; i < 600; i++) begin
      wa_r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 7));
      ra_r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 7));
      SE = ($urandom_range(0, 3) == 0);
      step(1'($urandom), wa_r, NB'($urandom), W'($urandom), 1'($urandom), ra_r);
      if ($urandom_range(0, 63) == 0) do_reset();
    end
    SE = 1'b0;
    for (int a = 0; a < 8; a++) step(1'b0, 0, '0, '0, 1'b1, a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scm_gen.md
Name: scm_gen

Overview:
- Parametrised successor to the fixed 256x16 standard-cell memory.
- Generalises depth and width, and adds per-byte write masking.
- Adds a registered read port with valid strobe, read-after-write forwarding and out-of-range address detection.
- Sits beside datapath blocks as a 1R1W register-file macro built from clock-gated latch/flop rows.

Parameters:
- WIDTH, 16, data word width in bits; must be a multiple of 8.
- DEPTH, 256, number of words; need not be a power of two.
- AW, 8, address width; must satisfy 2^AW >= DEPTH.
- NB, WIDTH/8, number of byte lanes (derived; not overridable).

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RSTN  input  1  asynchronous, active-low reset.
- SE  input  1  scan enable; forces all internal clock gates open; no functional effect on data.
- WE  input  1  write request.
- WADDR  input  AW  write address.
- WMASK  input  NB  byte-lane write enable; bit i covers DIN[8i+7:8i].
- DIN  input  WIDTH  write data.
- RE  input  1  read request.
- RADDR  input  AW  read address.
- DOUT  output  WIDTH  registered read data.
- RVALID  output  1  one-cycle strobe: DOUT updated at this edge.
- AERR  output  1  one-cycle strobe: a read or write request at this edge had address >= DEPTH.

Behaviour:
- Reset (RSTN=0, async): DOUT=0, RVALID=0, AERR=0, pending-write valid=0. Array contents are not reset and are undefined after power-up.
- Reset mid-operation: a sampled but uncommitted write is discarded; a read in flight produces no RVALID.
- Write pipeline, 2 stages:
  - Edge k: if WE=1 and WADDR<DEPTH, capture {WADDR, DIN, WMASK} into the pending register and set pending valid.
  - Edge k+1: commit pending data into row WADDR, only for lanes with WMASK=1; other lanes keep their old value.
  - Pending valid clears at edge k+1 unless a new write is sampled at the same edge (back-to-back writes, one per cycle, no stall).
- WE=1 with WMASK=0: consumes a pipeline slot; no data change.
- Read, latency 1:
  - Edge k with RE=1 and RADDR<DEPTH: DOUT <= mem[RADDR], read from array contents before the edge-k commit.
  - For each lane: if a committing pending write targets RADDR and has that lane masked on, that lane takes the pending data (forwarding).
  - A write sampled at the same edge k is not visible: read-before-write for the incoming request.
  - Net effect: a write sampled at edge k is visible to a read sampled at edge k+1 or later.
  - RVALID=1 for the cycle following edge k.
- RE=0: DOUT holds its last value; RVALID=0.
- Out-of-range address (>= DEPTH; only possible when DEPTH < 2^AW):
  - Write: dropped, no array change.
  - Read: DOUT <= 0 and RVALID=1.
  - AERR=1 for one cycle; if both the read and the write are out of range in the same cycle, AERR is still a single pulse.
- Simultaneous read and write to the same address at the same edge: the read returns old data (plus forwarding from any older pending write), as above.
- Clock gating:
  - One gate per row, enabled only on that row's commit cycle.
  - Data-capture and read-output registers are gated by WE and RE respectively.
  - SE=1 forces all gates open. Because row update is still qualified by the pending decode, SE introduces no spurious writes.
- Width rules:
  - Addresses are compared unsigned against DEPTH.
  - The read mux is an AW-bit decode, with the unused codes returning 0.

Test Plan:
1. Reset, then with RSTN=1: write 0xA5C3 to address 3 with WMASK=11, then read address 3 two cycles later -> DOUT=0xA5C3, RVALID=1 for exactly one cycle.
2. Mem[7]=0x1234. Write 0xFFFF to address 7 with WMASK=01 at edge k, read address 7 at edge k+1 -> DOUT=0x12FF via forwarding; a repeat read at k+3 -> 0x12FF from the array.
3. Mem[9]=0x0001. Write 0xBEEF to address 9 and read address 9 at the same edge -> DOUT=0x0001; a read at the next edge -> 0xBEEF.
4. DEPTH=200, AW=8: write 0x5555 to address 210 and read address 210 -> AERR pulses, DOUT=0, RVALID=1; a subsequent full scan of addresses 0..199 shows no change.
5. Issue a write to address 4, assert RSTN=0 before the commit edge, release reset, then read address 4 -> old contents returned; DOUT=0 and RVALID=0 during reset.
6. SE=1 with WE=RE=0 for 10 cycles -> array, DOUT and RVALID unchanged. Then run back-to-back writes to addresses 0..15, one per cycle, with WIDTH=32, and read them back -> all 16 words correct.
